// File: rtl/ps2_keymatrix_if.sv
// Bundles the PS/2 line and the keyboard-matrix side of ps2_keymatrix.
// master: keyboard/CPU side that drives the lines; slave: the decoder.
`timescale 1ns/1ps
interface ps2_keymatrix_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] rows;
    logic [4:0] cols;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_dat, rows,
        input  cols, scancode, scancode_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat, rows,
        output cols, scancode, scancode_valid, frame_err
    );
endinterface

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard receiver that maintains an 8x5 Spectrum-style key matrix.
// Optional PS2_PARITY_CHECK_EN: reject frames whose parity bit is wrong.
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data=0 on a strobe)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | sampling the parity bit
//   ST_STOP   | stop bit decides accept or frame error
`timescale 1ns/1ps
module ps2_keymatrix (
    input  logic          clk14,
    input  logic          reset,
    ps2_keymatrix_if.slave kb
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_DATA   = 2'd1;
    localparam logic [1:0]  ST_PARITY = 2'd2;
    localparam logic [1:0]  ST_STOP   = 2'd3;
    localparam logic [13:0] TMO_RELOAD = 14'd13999;
    localparam logic [2:0]  FLT_RELOAD = 3'd7;

    logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic       filt_q, filt_d;
    logic [2:0] flt_cnt_q, flt_cnt_d;
    logic       strobe;

    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        perr_q, perr_d;
    logic [13:0] tmo_q, tmo_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic [7:0]  scancode_q, scancode_d;
    logic        accept;

    logic             ext_q, ext_d, brk_q, brk_d;
    logic [7:0][4:0]  key_q, key_d;
    logic [6:0]       map;
    logic [4:0]       cols_w;

    // {hit, row, col} for each mapped make code
    function automatic logic [6:0] key_map(input logic [7:0] code);
        logic [6:0] m;
        m = 7'd0;
        case (code)
            8'h12: m = {1'b1, 3'd0, 3'd0};  8'h1A: m = {1'b1, 3'd0, 3'd1};
            8'h22: m = {1'b1, 3'd0, 3'd2};  8'h21: m = {1'b1, 3'd0, 3'd3};
            8'h2A: m = {1'b1, 3'd0, 3'd4};
            8'h1C: m = {1'b1, 3'd1, 3'd0};  8'h1B: m = {1'b1, 3'd1, 3'd1};
            8'h23: m = {1'b1, 3'd1, 3'd2};  8'h2B: m = {1'b1, 3'd1, 3'd3};
            8'h34: m = {1'b1, 3'd1, 3'd4};
            8'h15: m = {1'b1, 3'd2, 3'd0};  8'h1D: m = {1'b1, 3'd2, 3'd1};
            8'h24: m = {1'b1, 3'd2, 3'd2};  8'h2D: m = {1'b1, 3'd2, 3'd3};
            8'h2C: m = {1'b1, 3'd2, 3'd4};
            8'h16: m = {1'b1, 3'd3, 3'd0};  8'h1E: m = {1'b1, 3'd3, 3'd1};
            8'h26: m = {1'b1, 3'd3, 3'd2};  8'h25: m = {1'b1, 3'd3, 3'd3};
            8'h2E: m = {1'b1, 3'd3, 3'd4};
            8'h45: m = {1'b1, 3'd4, 3'd0};  8'h46: m = {1'b1, 3'd4, 3'd1};
            8'h3E: m = {1'b1, 3'd4, 3'd2};  8'h3D: m = {1'b1, 3'd4, 3'd3};
            8'h36: m = {1'b1, 3'd4, 3'd4};
            8'h4D: m = {1'b1, 3'd5, 3'd0};  8'h44: m = {1'b1, 3'd5, 3'd1};
            8'h43: m = {1'b1, 3'd5, 3'd2};  8'h3C: m = {1'b1, 3'd5, 3'd3};
            8'h35: m = {1'b1, 3'd5, 3'd4};
            8'h5A: m = {1'b1, 3'd6, 3'd0};  8'h4B: m = {1'b1, 3'd6, 3'd1};
            8'h42: m = {1'b1, 3'd6, 3'd2};  8'h3B: m = {1'b1, 3'd6, 3'd3};
            8'h33: m = {1'b1, 3'd6, 3'd4};
            8'h29: m = {1'b1, 3'd7, 3'd0};  8'h14: m = {1'b1, 3'd7, 3'd1};
            8'h3A: m = {1'b1, 3'd7, 3'd2};  8'h31: m = {1'b1, 3'd7, 3'd3};
            8'h32: m = {1'b1, 3'd7, 3'd4};
            default: m = 7'd0;
        endcase
        return m;
    endfunction

    // Filtered clock flips on the 8th consecutive sample that disagrees with it
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = FLT_RELOAD;
        strobe    = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q == 3'd0) begin
                filt_d = clk_s2_q;
                strobe = filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        perr_d     = perr_q;
        tmo_d      = tmo_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        scancode_d = scancode_q;
        accept     = 1'b0;
        if (strobe) begin
            tmo_d = TMO_RELOAD;
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        par_d     = 1'b0;
                        perr_d    = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    par_d   = par_q ^ dat_s2_q;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    perr_d = ~(par_q ^ dat_s2_q);
`endif
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (dat_s2_q && !perr_q) begin
                        accept     = 1'b1;
                        valid_d    = 1'b1;
                        scancode_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == 14'd0) state_d = ST_IDLE;
            else                tmo_d   = tmo_q - 14'd1;
        end else begin
            tmo_d = TMO_RELOAD;
        end
    end

    assign map = key_map(shift_q);

    always_comb begin
        key_d = key_q;
        ext_d = ext_q;
        brk_d = brk_q;
        if (accept) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (shift_q == 8'hAA)
                    key_d = '0;
                else if (!ext_q && map[6])
                    key_d[map[5:3]][map[2:0]] = ~brk_q;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Row selects are wired-AND onto the shared column lines
    always_comb begin
        cols_w = 5'b11111;
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 5; k++)
                if (!kb.rows[n] && key_q[n][k]) cols_w[k] = 1'b0;
    end

    always_ff @(posedge clk14 or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            flt_cnt_q  <= FLT_RELOAD;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            tmo_q      <= TMO_RELOAD;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            scancode_q <= 8'h00;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_q      <= '0;
        end else begin
            clk_s1_q   <= kb.ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= kb.ps2_dat;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            flt_cnt_q  <= flt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            tmo_q      <= tmo_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            scancode_q <= scancode_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_q      <= key_d;
        end
    end

    assign kb.cols           = cols_w;
    assign kb.scancode       = scancode_q;
    assign kb.scancode_valid = valid_q;
    assign kb.frame_err      = ferr_q;
endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix: vector table of key sequences plus
// hand-written frame-error, parity, timeout and mid-frame reset cases.
`timescale 1ns/1ps
module tb_ps2_keymatrix;
    localparam int HB = 16;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        logic [7:0] rows;
        logic [4:0] cols;
        int         dvalid;
        logic [7:0] sc;
    } vec_t;

    logic clk14 = 1'b0;
    logic reset;
    ps2_keymatrix_if kb();

    ps2_keymatrix dut (.clk14(clk14), .reset(reset), .kb(kb));

    always #5 clk14 = ~clk14;

    int tests = 0;
    int fails = 0;
    int vcnt = 0;
    int fcnt = 0;
    logic [4:0] cols_at_valid = 5'b11111;

    always @(negedge clk14) begin
        if (kb.scancode_valid) begin
            vcnt++;
            cols_at_valid = kb.cols;
        end
        if (kb.frame_err) fcnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        kb.ps2_dat = b;
        repeat (HB) @(negedge clk14);
        kb.ps2_clk = 1'b0;
        repeat (HB) @(negedge clk14);
        kb.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
        logic p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        p = ~^b;
        if (!par_ok) p = ~p;
        send_bit(p);
        send_bit(stop);
        kb.ps2_dat = 1'b1;
        repeat (2 * HB) @(negedge clk14);
    endtask

    task automatic set_rows(input logic [7:0] r);
        kb.rows = r;
        repeat (2) @(negedge clk14);
    endtask

    vec_t vecs[17];

    initial begin
        int v0, f0;
        vecs[0]  = '{8'h1C, 8'h00, 8'h00, 1, 8'hFD, 5'b11110, 1, 8'h1C};
        vecs[1]  = '{8'hF0, 8'h1C, 8'h00, 2, 8'hFD, 5'b11111, 2, 8'h1C};
        vecs[2]  = '{8'h12, 8'h29, 8'h00, 2, 8'h7E, 5'b11110, 2, 8'h29};
        vecs[3]  = '{8'h00, 8'h00, 8'h00, 0, 8'hFF, 5'b11111, 0, 8'h29};
        vecs[4]  = '{8'h00, 8'h00, 8'h00, 0, 8'hFE, 5'b11110, 0, 8'h29};
        vecs[5]  = '{8'hE0, 8'h1C, 8'h00, 2, 8'hFD, 5'b11111, 2, 8'h1C};
        vecs[6]  = '{8'h1C, 8'h00, 8'h00, 1, 8'hFD, 5'b11110, 1, 8'h1C};
        vecs[7]  = '{8'h14, 8'h00, 8'h00, 1, 8'h7F, 5'b11100, 1, 8'h14};
        vecs[8]  = '{8'h00, 8'h00, 8'h00, 0, 8'h7D, 5'b11100, 0, 8'h14};
        vecs[9]  = '{8'h4D, 8'h00, 8'h00, 1, 8'hDF, 5'b11110, 1, 8'h4D};
        vecs[10] = '{8'h33, 8'h00, 8'h00, 1, 8'hBF, 5'b01111, 1, 8'h33};
        vecs[11] = '{8'h5E, 8'h00, 8'h00, 1, 8'h00, 5'b01100, 1, 8'h5E};
        vecs[12] = '{8'hE0, 8'hF0, 8'h12, 3, 8'hFE, 5'b11110, 3, 8'h12};
        vecs[13] = '{8'hF0, 8'h12, 8'h00, 2, 8'hFE, 5'b11111, 2, 8'h12};
        vecs[14] = '{8'hAA, 8'h00, 8'h00, 1, 8'h00, 5'b11111, 1, 8'hAA};
        vecs[15] = '{8'h2A, 8'h00, 8'h00, 1, 8'hFE, 5'b01111, 1, 8'h2A};
        vecs[16] = '{8'h3A, 8'h00, 8'h00, 1, 8'h7F, 5'b11011, 1, 8'h3A};

        kb.ps2_clk = 1'b1;
        kb.ps2_dat = 1'b1;
        kb.rows    = 8'h00;
        reset      = 1'b1;
        repeat (4) @(negedge clk14);
        check("reset_cols", {27'd0, kb.cols}, 32'h1F);
        check("reset_scancode", {24'd0, kb.scancode}, 32'h00);
        check("reset_valid", {31'd0, kb.scancode_valid}, 32'd0);
        check("reset_ferr", {31'd0, kb.frame_err}, 32'd0);
        reset = 1'b0;
        kb.rows = 8'hFF;
        repeat (4) @(negedge clk14);

        for (int i = 0; i < 17; i++) begin
            v0 = vcnt;
            f0 = fcnt;
            if (vecs[i].nb > 0) send_frame(vecs[i].b0, 1'b1, 1'b1);
            if (vecs[i].nb > 1) send_frame(vecs[i].b1, 1'b1, 1'b1);
            if (vecs[i].nb > 2) send_frame(vecs[i].b2, 1'b1, 1'b1);
            set_rows(vecs[i].rows);
            check($sformatf("vec%0d_cols", i), {27'd0, kb.cols}, {27'd0, vecs[i].cols});
            check($sformatf("vec%0d_valid", i), vcnt - v0, vecs[i].dvalid);
            check($sformatf("vec%0d_ferr", i), fcnt - f0, 0);
            check($sformatf("vec%0d_scancode", i), {24'd0, kb.scancode}, {24'd0, vecs[i].sc});
        end

        // Stop bit 0: frame error, byte discarded
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h1B, 1'b1, 1'b0);
        set_rows(8'hFD);
        check("stop0_ferr", fcnt - f0, 1);
        check("stop0_valid", vcnt - v0, 0);
        check("stop0_scancode", {24'd0, kb.scancode}, 32'h3A);
        check("stop0_cols", {27'd0, kb.cols}, 32'h1F);

        // Bad parity
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h1B, 1'b0, 1'b1);
        set_rows(8'hFD);
`ifdef PS2_PARITY_CHECK_EN
        check("badpar_ferr", fcnt - f0, 1);
        check("badpar_valid", vcnt - v0, 0);
        check("badpar_cols", {27'd0, kb.cols}, 32'h1F);
`else
        check("badpar_ferr", fcnt - f0, 0);
        check("badpar_valid", vcnt - v0, 1);
        check("badpar_scancode", {24'd0, kb.scancode}, 32'h1B);
        check("badpar_cols", {27'd0, kb.cols}, 32'h1D);
`endif
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);

        // Matrix must already reflect the byte while scancode_valid is high
        kb.rows = 8'hFD;
        send_frame(8'h2B, 1'b1, 1'b1);
        check("valid_edge_cols", {27'd0, cols_at_valid}, 32'h17);

        // Stalled partial frame times out, next frame decodes cleanly
        send_frame(8'hAA, 1'b1, 1'b1);
        v0 = vcnt; f0 = fcnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        kb.ps2_dat = 1'b1;
        repeat (15000) @(negedge clk14);
        send_frame(8'h2A, 1'b1, 1'b1);
        set_rows(8'hFE);
        check("tmo_valid", vcnt - v0, 1);
        check("tmo_ferr", fcnt - f0, 0);
        check("tmo_scancode", {24'd0, kb.scancode}, 32'h2A);
        check("tmo_cols", {27'd0, kb.cols}, 32'h0F);

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk14);
        reset = 1'b0;
        set_rows(8'h00);
        check("midrst_cols", {27'd0, kb.cols}, 32'h1F);
        check("midrst_scancode", {24'd0, kb.scancode}, 32'h00);
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        set_rows(8'hFD);
        check("postrst_valid", vcnt - v0, 1);
        check("postrst_ferr", fcnt - f0, 0);
        check("postrst_scancode", {24'd0, kb.scancode}, 32'h1C);
        check("postrst_cols", {27'd0, kb.cols}, 32'h1E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
